pong_match_ctrl: RTL and testbench

//  Match sequencer for the pong datapath. It gates ball/paddle updates (run_o) and

---
 rtl/pong_match_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pong_match_ctrl : serve/rally/point/over sequencer with scores, winner, pause
// Revision 1.0
// ----------------------------------------------------------------------------
module pong_match_ctrl #(
  parameter int X_POS_W      = 10,
  parameter int SCREEN_H_RES = 640,
  parameter int LEFT_MISS    = 1,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               new_frame_i,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  output logic               run_o,
  output logic               ball_hold_o,
  output logic               serve_dir_o,
  output logic [3:0]         score_player_o,
  output logic [3:0]         score_enemy_o,
  output logic               point_o,
  output logic               winner_o,
  output logic [2:0]         state_o,
  output logic               paused_o
);

  localparam int CNT_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
  localparam logic [3:0]         WIN_S      = 4'(WIN_SCORE);
  localparam logic [X_POS_W-1:0] RIGHT_X    = X_POS_W'(SCREEN_H_RES);
  localparam logic [X_POS_W-1:0] LEFT_X     = X_POS_W'(LEFT_MISS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RALLY = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score_player_q, score_player_d;
  logic [3:0]       score_enemy_q, score_enemy_d;
  logic             winner_q, winner_d;
  logic             serve_dir_q, serve_dir_d;
  logic             paused_q, paused_d;
  logic             scorer_q, scorer_d;
  logic             run_q, run_d;
  logic             hold_q, hold_d;
  logic             point_q, point_d;
  logic             start_cur_q, start_cur_d;
  logic             start_prev_q, start_prev_d;
  logic             pause_cur_q, pause_cur_d;
  logic             pause_prev_q, pause_prev_d;
  logic [1:0]       arm_q, arm_d;

  logic       start_edge;
  logic       pause_edge;
  logic       frame_tick;
  logic       right_miss;
  logic       left_miss;
  logic [3:0] scored;
  logic [3:0] new_score;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    score_player_d = score_player_q;
    score_enemy_d  = score_enemy_q;
    winner_d       = winner_q;
    serve_dir_d    = serve_dir_q;
    paused_d       = paused_q;
    scorer_d       = scorer_q;
    start_cur_d    = start_i;
    start_prev_d   = start_cur_q;
    pause_cur_d    = pause_i;
    pause_prev_d   = pause_cur_q;
    arm_d          = {arm_q[0], 1'b1};

    // Edges need two post-reset key samples, so a key held through reset is not a press.
    start_edge = start_cur_q & ~start_prev_q & arm_q[1];
    pause_edge = pause_cur_q & ~pause_prev_q & arm_q[1];
    frame_tick = new_frame_i & ~paused_q;
    right_miss = (ball_x_i >= RIGHT_X);
    left_miss  = (ball_x_i < LEFT_X);
    scored     = scorer_q ? score_enemy_q : score_player_q;
    new_score  = (scored >= WIN_S) ? WIN_S : scored + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          score_player_d = 4'd0;
          score_enemy_d  = 4'd0;
          winner_d       = 1'b0;
          serve_dir_d    = 1'b0;
          cnt_d          = '0;
          state_d        = S_SERVE;
        end
      end
      S_SERVE: begin
        if (pause_edge) paused_d = ~paused_q;
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = S_RALLY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RALLY: begin
        if (frame_tick && (right_miss || left_miss)) begin
          scorer_d = right_miss;
          state_d  = S_POINT;
        end else if (pause_edge) begin
          paused_d = ~paused_q;
        end
      end
      S_POINT: begin
        if (scorer_q) score_enemy_d = new_score;
        else          score_player_d = new_score;
        serve_dir_d = ~scorer_q;
        cnt_d       = '0;
        if (new_score == WIN_S) begin
          winner_d = scorer_q;
          state_d  = S_OVER;
        end else begin
          state_d = S_SERVE;
        end
      end
      S_OVER: begin
        if (new_frame_i) begin
          if (cnt_q == OVER_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != S_SERVE && state_d != S_RALLY) paused_d = 1'b0;

    run_d   = (state_d == S_RALLY) && !paused_d;
    hold_d  = (state_d != S_RALLY);
    point_d = (state_d == S_POINT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      score_player_q <= 4'd0;
      score_enemy_q  <= 4'd0;
      winner_q       <= 1'b0;
      serve_dir_q    <= 1'b0;
      paused_q       <= 1'b0;
      scorer_q       <= 1'b0;
      run_q          <= 1'b0;
      hold_q         <= 1'b0;
      point_q        <= 1'b0;
      start_cur_q    <= 1'b0;
      start_prev_q   <= 1'b0;
      pause_cur_q    <= 1'b0;
      pause_prev_q   <= 1'b0;
      arm_q          <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      score_player_q <= score_player_d;
      score_enemy_q  <= score_enemy_d;
      winner_q       <= winner_d;
      serve_dir_q    <= serve_dir_d;
      paused_q       <= paused_d;
      scorer_q       <= scorer_d;
      run_q          <= run_d;
      hold_q         <= hold_d;
      point_q        <= point_d;
      start_cur_q    <= start_cur_d;
      start_prev_q   <= start_prev_d;
      pause_cur_q    <= pause_cur_d;
      pause_prev_q   <= pause_prev_d;
      arm_q          <= arm_d;
    end
  end

  assign run_o          = run_q;
  assign ball_hold_o    = hold_q;
  assign serve_dir_o    = serve_dir_q;
  assign score_player_o = score_player_q;
  assign score_enemy_o  = score_enemy_q;
  assign point_o        = point_q;
  assign winner_o       = winner_q;
  assign state_o        = state_q;
  assign paused_o       = paused_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pong_match_ctrl : directed + randomized bench against a match-rule model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pong_match_ctrl;

  localparam int SERVE_N = 60;
  localparam int OVER_N  = 180;
  localparam int WIN_N   = 7;

  logic       clk;
  logic       rst_ni;
  logic       new_frame_i;
  logic       start_i;
  logic       pause_i;
  logic [9:0] ball_x_i;
  logic       run_o, ball_hold_o, serve_dir_o, point_o, winner_o, paused_o;
  logic [3:0] score_player_o, score_enemy_o;
  logic [2:0] state_o;

  pong_match_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .new_frame_i    (new_frame_i),
    .start_i        (start_i),
    .pause_i        (pause_i),
    .ball_x_i       (ball_x_i),
    .run_o          (run_o),
    .ball_hold_o    (ball_hold_o),
    .serve_dir_o    (serve_dir_o),
    .score_player_o (score_player_o),
    .score_enemy_o  (score_enemy_o),
    .point_o        (point_o),
    .winner_o       (winner_o),
    .state_o        (state_o),
    .paused_o       (paused_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Match model: phase numbers are the state_o codes, scores indexed 0=player 1=enemy.
  int m_phase, m_frames, m_winner, m_dir, m_paused, m_scorer, m_in_reset;
  int m_score[2];
  bit model_ok = 1'b0;
  bit s_hist[$];
  bit p_hist[$];
  int e_state, e_run, e_hold, e_dir, e_sp, e_se, e_point, e_win, e_paused;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_ni) begin
        m_phase = 0; m_frames = 0; m_winner = 0; m_dir = 0; m_paused = 0; m_scorer = 0;
        m_score[0] = 0; m_score[1] = 0;
        s_hist.delete(); p_hist.delete();
        m_in_reset = 1;
        model_ok = 1'b1;
      end else if (model_ok) begin
        bit s_edge, p_edge, tick;
        int bx;
        s_edge = (s_hist.size() == 2) && s_hist[1] && !s_hist[0];
        p_edge = (p_hist.size() == 2) && p_hist[1] && !p_hist[0];
        s_hist.push_back(start_i);
        p_hist.push_back(pause_i);
        if (s_hist.size() > 2) void'(s_hist.pop_front());
        if (p_hist.size() > 2) void'(p_hist.pop_front());
        tick = new_frame_i && (m_paused == 0);
        bx = int'(ball_x_i);
        m_in_reset = 0;
        case (m_phase)
          0: if (s_edge) begin
               m_score[0] = 0; m_score[1] = 0; m_winner = 0; m_dir = 0;
               m_frames = 0; m_phase = 1;
             end
          1: begin
               if (p_edge) m_paused = 1 - m_paused;
               if (tick) begin
                 m_frames++;
                 if (m_frames == SERVE_N) begin m_frames = 0; m_phase = 2; end
               end
             end
          2: begin
               if (tick && (bx >= 640 || bx < 1)) begin
                 m_scorer = (bx >= 640) ? 1 : 0;
                 m_phase = 3;
               end else if (p_edge) begin
                 m_paused = 1 - m_paused;
               end
             end
          3: begin
               m_score[m_scorer] = (m_score[m_scorer] + 1 > WIN_N) ? WIN_N : m_score[m_scorer] + 1;
               m_dir = (m_scorer == 1) ? 0 : 1;
               m_frames = 0;
               if (m_score[m_scorer] == WIN_N) begin m_winner = m_scorer; m_phase = 4; end
               else m_phase = 1;
             end
          default: if (new_frame_i) begin
               m_frames++;
               if (m_frames == OVER_N) begin m_frames = 0; m_phase = 0; end
             end
        endcase
        if (m_phase == 0 || m_phase == 3 || m_phase == 4) m_paused = 0;
      end
      if (m_in_reset != 0) begin
        e_state = 0; e_run = 0; e_hold = 0; e_dir = 0; e_sp = 0; e_se = 0;
        e_point = 0; e_win = 0; e_paused = 0;
      end else begin
        e_state = m_phase; e_run = (m_phase == 2 && m_paused == 0) ? 1 : 0;
        e_hold = (m_phase != 2) ? 1 : 0; e_dir = m_dir; e_sp = m_score[0];
        e_se = m_score[1]; e_point = (m_phase == 3) ? 1 : 0; e_win = m_winner;
        e_paused = m_paused;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        n_cmp++;
        if (int'(state_o) != e_state || int'(run_o) != e_run || int'(ball_hold_o) != e_hold ||
            int'(serve_dir_o) != e_dir || int'(score_player_o) != e_sp ||
            int'(score_enemy_o) != e_se || int'(point_o) != e_point ||
            int'(winner_o) != e_win || int'(paused_o) != e_paused) begin
          n_bad++;
          $display("FAIL cycle t=%0t got st=%0d run=%0b hold=%0b dir=%0b sp=%0d se=%0d pt=%0b win=%0b pa=%0b want st=%0d run=%0d hold=%0d dir=%0d sp=%0d se=%0d pt=%0d win=%0d pa=%0d",
                   $time, state_o, run_o, ball_hold_o, serve_dir_o, score_player_o, score_enemy_o,
                   point_o, winner_o, paused_o, e_state, e_run, e_hold, e_dir, e_sp, e_se,
                   e_point, e_win, e_paused);
        end
      end
    end
  end

  task automatic pin(input string name, input int dut_v, input int mdl_v, input int want);
    n_cmp++;
    if (dut_v != want) begin
      n_bad++;
      $display("FAIL pin %s: dut=%0d required=%0d", name, dut_v, want);
    end
    n_cmp++;
    if (mdl_v != want) begin
      n_bad++;
      $display("FAIL pin %s (model): model=%0d required=%0d", name, mdl_v, want);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic strobe(input int x);
    ball_x_i = 10'(x);
    new_frame_i = 1'b1;
    cyc();
    new_frame_i = 1'b0;
    ball_x_i = 10'd320;
  endtask

  task automatic frame(input int x);
    strobe(x);
    cyc();
  endtask

  task automatic frames(input int n);
    repeat (n) frame(int'($urandom_range(639, 1)));
  endtask

  task automatic press_start();
    start_i = 1'b1; cyc(3); start_i = 1'b0; cyc(2);
  endtask

  task automatic press_pause();
    pause_i = 1'b1; cyc(3); pause_i = 1'b0; cyc(2);
  endtask

  initial begin
    rst_ni = 1'b0; new_frame_i = 1'b0; start_i = 1'b1; pause_i = 1'b0; ball_x_i = 10'd320;
    cyc(3);
    pin("reset_state", int'(state_o), e_state, 0);
    pin("reset_hold", int'(ball_hold_o), e_hold, 0);
    rst_ni = 1'b1;
    cyc(5);
    pin("held_start_no_edge", int'(state_o), e_state, 0);
    pin("idle_hold", int'(ball_hold_o), e_hold, 1);
    start_i = 1'b0; cyc(2);

    press_start();
    pin("serve_state", int'(state_o), e_state, 1);
    frames(SERVE_N - 1);
    pin("serve_59", int'(state_o), e_state, 1);
    frame(320);
    pin("rally_state", int'(state_o), e_state, 2);
    pin("rally_run", int'(run_o), e_run, 1);

    strobe(640);
    pin("point_pulse", int'(point_o), e_point, 1);
    pin("point_state", int'(state_o), e_state, 3);
    cyc();
    pin("enemy_score1", int'(score_enemy_o), e_se, 1);
    pin("dir_to_player", int'(serve_dir_o), e_dir, 0);
    pin("back_to_serve", int'(state_o), e_state, 1);
    pin("point_one_cycle", int'(point_o), e_point, 0);

    frames(30);
    press_pause();
    frames(100);
    pin("serve_paused", int'(state_o), e_state, 1);
    pin("paused_flag", int'(paused_o), e_paused, 1);
    press_pause();
    frames(29);
    pin("serve_resumed_29", int'(state_o), e_state, 1);
    frame(320);
    pin("rally_after_resume", int'(state_o), e_state, 2);

    press_pause();
    pin("rally_paused_run", int'(run_o), e_run, 0);
    frame(640);
    pin("miss_ignored_paused", int'(state_o), e_state, 2);
    press_pause();
    pin("rally_unpaused_run", int'(run_o), e_run, 1);
    frame(640);
    pin("enemy_score2", int'(score_enemy_o), e_se, 2);

    for (int i = 0; i < WIN_N; i++) begin
      frames(SERVE_N);
      frame(0);
    end
    pin("over_state", int'(state_o), e_state, 4);
    pin("winner_player", int'(winner_o), e_win, 0);
    pin("player_7", int'(score_player_o), e_sp, 7);
    pin("dir_to_enemy", int'(serve_dir_o), e_dir, 1);
    press_start();
    pin("start_ignored_over", int'(state_o), e_state, 4);
    frames(OVER_N - 1);
    pin("over_179", int'(state_o), e_state, 4);
    frame(320);
    pin("idle_after_over", int'(state_o), e_state, 0);
    pin("idle_score_held", int'(score_player_o), e_sp, 7);
    press_start();
    pin("scores_cleared", int'(score_player_o), e_sp, 0);

    for (int c = 0; c < 20000; c++) begin
      int r;
      new_frame_i = ($urandom_range(2) == 0);
      r = int'($urandom_range(99));
      if (r < 8) ball_x_i = 10'd0;
      else if (r < 16) ball_x_i = 10'($urandom_range(1023, 640));
      else ball_x_i = 10'($urandom_range(639, 1));
      if ($urandom_range(39) == 0) start_i = ~start_i;
      if ($urandom_range(29) == 0) pause_i = ~pause_i;
      rst_ni = ($urandom_range(4999) != 0);
      cyc();
    end

    new_frame_i = 1'b0; start_i = 1'b0; pause_i = 1'b0; ball_x_i = 10'd320;
    rst_ni = 1'b0; cyc(2); rst_ni = 1'b1; cyc(3);
    press_start();
    frames(SERVE_N); frame(640);
    frames(SERVE_N); frame(640);
    for (int i = 0; i < 3; i++) begin
      frames(SERVE_N);
      frame(0);
    end
    frames(SERVE_N);
    pin("mid_rally_state", int'(state_o), e_state, 2);
    pin("mid_player3", int'(score_player_o), e_sp, 3);
    pin("mid_enemy2", int'(score_enemy_o), e_se, 2);
    start_i = 1'b1;
    rst_ni = 1'b0;
    cyc();
    pin("abort_state", int'(state_o), e_state, 0);
    pin("abort_run", int'(run_o), e_run, 0);
    pin("abort_player", int'(score_player_o), e_sp, 0);
    cyc(2);
    rst_ni = 1'b1;
    cyc(6);
    pin("abort_held_start", int'(state_o), e_state, 0);
    start_i = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
